p2s_tx: RTL and testbench

//   Parallel-to-serial transmitter; the sending end of the sync/serial-data link.
//   - Accepts a width-bit word through a load/ack handshake.
//   - Drives it onto data_out MSB first, one bit per clk.
//   - Pulses sync with the first (MSB) bit so the receiver can frame the word.
//   - Pulses done after the last bit; sits between the word producer and the serial wire.

---
 rtl/p2s_tx.sv | 121 ++++++++++++
 tb/tb_p2s_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/p2s_tx.sv
// p2s_tx: parallel-to-serial transmitter, MSB first, with sync/done framing.
// A word is accepted through load/ack while idle, shifted out one bit per clk,
// followed by a done pulse and an optional run of busy gap cycles.
// Optional feature macro: P2S_PARITY_EN appends one even-parity bit after the LSB.
module p2s_tx #(
  parameter int width = 8,
  parameter int gap   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [width-1:0] data_in,
  output logic             ack,
  output logic             busy,
  output logic             sync,
  output logic             data_out,
  output logic             done
);

  localparam int CW = $clog2(width + 1);
  localparam int GW = (gap > 1) ? $clog2(gap) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  state_t           state, nxt_state;
  logic [width-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             accept, last, frame_end;
  logic             nxt_ack, nxt_busy, nxt_sync, nxt_dout, nxt_done;
`ifdef P2S_PARITY_EN
  logic             par;
`endif

  // load is only honoured from IDLE, which is exactly when busy is low
  assign accept = (state == IDLE) && load;
  // cnt counts bits already on the wire; width means the LSB just went out
  assign last   = (state == SHIFT) && (cnt == CW'(width));
`ifdef P2S_PARITY_EN
  assign frame_end = (state == PARITY);
`else
  assign frame_end = last;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt_state;
  end

  // next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:   if (load) nxt_state = SHIFT;
`ifdef P2S_PARITY_EN
      SHIFT:  if (last) nxt_state = PARITY;
      PARITY: nxt_state = (gap > 0) ? GAP : IDLE;
`else
      SHIFT:  if (last) nxt_state = (gap > 0) ? GAP : IDLE;
      PARITY: nxt_state = IDLE;
`endif
      GAP:    if (gcnt == '0) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    nxt_ack  = accept;
    nxt_sync = accept;
    nxt_busy = (nxt_state != IDLE);
    nxt_done = frame_end;
    nxt_dout = 1'b0;
    if (accept)                 nxt_dout = data_in[width-1];
    else if (state == SHIFT && !last) nxt_dout = sr[width-1];
`ifdef P2S_PARITY_EN
    else if (last)              nxt_dout = par;
`endif
  end

  // output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack <= 1'b0; busy <= 1'b0; sync <= 1'b0; data_out <= 1'b0; done <= 1'b0;
    end else begin
      ack <= nxt_ack; busy <= nxt_busy; sync <= nxt_sync;
      data_out <= nxt_dout; done <= nxt_done;
    end
  end

  // shift register and bit counter; MSB leaves on accept, so store the rest pre-shifted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= {data_in[width-2:0], 1'b0};
      cnt <= CW'(1);
    end else if (state == SHIFT && !last) begin
      sr  <= {sr[width-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end
  end

  // gap counter: holds the number of gap cycles left after the current one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        gcnt <= '0;
    else if (frame_end)                  gcnt <= GW'((gap > 0) ? gap - 1 : 0);
    else if (state == GAP && gcnt != '0) gcnt <= gcnt - GW'(1);
  end

`ifdef P2S_PARITY_EN
  // even parity over the whole word, taken when the word is captured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    par <= 1'b0;
    else if (accept) par <= ^data_in;
  end
`endif

endmodule

// File: tb/tb_p2s_tx.sv
// Directed bench for p2s_tx: a gap=1 instance for framing, reset and
// back-to-back loads, and a gap=3 instance for gap-cycle load rejection.
module tb_p2s_tx;

`ifdef P2S_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int P = 10 + PAR;   // frame period with gap=1

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0, load3 = 1'b0;
  logic [7:0] data_in = '0, data3 = '0;
  logic       ack, busy, sync, dout, done;
  logic       ack3, busy3, sync3, dout3, done3;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  p2s_tx #(.width(8), .gap(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in),
    .ack(ack), .busy(busy), .sync(sync), .data_out(dout), .done(done));

  p2s_tx #(.width(8), .gap(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .load(load3), .data_in(data3),
    .ack(ack3), .busy(busy3), .sync(sync3), .data_out(dout3), .done(done3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot = ntot + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one full frame on the gap=1 instance with every output checked per cycle
  task automatic send_check(input logic [7:0] w, input string tag);
    load = 1'b1; data_in = w;
    step();
    chk({tag, " c1 ack/sync/busy/dout"}, {ack, sync, busy, dout}, {3'b111, w[7]});
    load = 1'b0; data_in = ~w;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("%s c%0d ack/sync/busy/dout/done", tag, i + 1),
          {ack, sync, busy, dout, done}, {3'b001, w[7-i], 1'b0});
    end
    if (PAR == 1) begin
      step();
      chk({tag, " parity bit/done"}, {dout, done}, {^w, 1'b0});
    end
    step();
    chk({tag, " done cycle done/busy/dout"}, {done, busy, dout}, 3'b110);
    step();
    chk({tag, " idle done/busy"}, {done, busy}, 2'b00);
  endtask

  logic rec_ack [1:2*P];
  logic rec_sync[1:2*P];
  logic rec_dout[1:2*P];

  initial begin
    logic [7:0] w1, w2;
    int na, ns, k;
    logic saw_done;

    // reset state
    step(); step();
    chk("reset outputs", {ack, busy, sync, dout, done}, 5'b0);
    chk("reset outputs g3", {ack3, busy3, sync3, dout3, done3}, 5'b0);
    reset_n = 1'b1;
    step();

    // single frames
    send_check(8'hA5, "A5");
    send_check(8'h07, "07");

    // load held high, word changed after first ack
    w1 = 8'h3C; w2 = 8'hC3;
    load = 1'b1; data_in = w1;
    for (int c = 1; c <= 2*P; c++) begin
      step();
      rec_ack[c] = ack; rec_sync[c] = sync; rec_dout[c] = dout;
      if (c == 1) data_in = w2;
    end
    load = 1'b0;
    na = 0; ns = 0;
    for (int c = 1; c <= 2*P; c++) begin
      na = na + int'(rec_ack[c]);
      ns = ns + int'(rec_sync[c]);
    end
    chk("held: ack count", na, 2);
    chk("held: sync count", ns, 2);
    chk("held: sync at 1 and P+1", {rec_sync[1], rec_sync[P+1]}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("held: frame1 bit%0d", i), rec_dout[1+i], w1[7-i]);
      chk($sformatf("held: frame2 bit%0d", i), rec_dout[P+1+i], w2[7-i]);
    end
    k = 0;
    while (busy && k < 30) begin step(); k++; end
    chk("held: back to idle", busy, 1'b0);

    // reset during bit 4 of FF
    load = 1'b1; data_in = 8'hFF;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("FF mid-frame busy/dout", {busy, dout}, 2'b11);
    #2 reset_n = 1'b0;
    #1 chk("async reset outputs", {ack, busy, sync, dout, done}, 5'b0);
    #2 reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      saw_done = saw_done | done | busy;
    end
    chk("no done/busy after reset", saw_done, 1'b0);
    send_check(8'h01, "01 after reset");

    // gap=3: loads during gap ignored, first load after busy=0 accepted
    load3 = 1'b1; data3 = 8'h81;
    step();
    chk("g3 ack", {ack3, sync3, busy3, dout3}, 4'b1111);
    load3 = 1'b0;
    for (int i = 0; i < 7 + PAR; i++) step();
    chk("g3 before done", {done3, busy3}, 2'b01);
    load3 = 1'b1; data3 = 8'h55;
    for (int g = 1; g <= 3; g++) begin
      step();
      chk($sformatf("g3 gap%0d ack/busy/done", g), {ack3, busy3, done3},
          {1'b0, 1'b1, (g == 1) ? 1'b1 : 1'b0});
    end
    step();
    chk("g3 idle ack/busy", {ack3, busy3}, 2'b00);
    step();
    chk("g3 reload ack/dout", {ack3, busy3, dout3}, 3'b110);
    load3 = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
